// File: rtl/scope_trig_ctrl.sv
// scope_trig_ctrl: acquisition sequencer for the scope capture path.
// Fills a circular buffer with pre-trigger history, trigger and post samples.
module scope_trig_ctrl #(
  parameter int ADDR_W = 10,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              smp_en,
  input  logic              positive,
  input  logic              negative,
  input  logic [1:0]        cfg_edge,
  input  logic              cfg_auto,
  input  logic [ADDR_W-1:0] cfg_pre,
  input  logic [ADDR_W-1:0] cfg_post,
  input  logic [TMO_W-1:0]  cfg_tmo,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              triggered,
  output logic              auto_fired,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } st_t;

  localparam logic [ADDR_W-1:0] A1 = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  T1 = {{(TMO_W-1){1'b0}}, 1'b1};

  st_t st, nxt;

  logic [1:0]        edge_q;
  logic              auto_q;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] post_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic go, act, wr, edge_hit, hit, tmo_hit, fire;

  always_comb begin
    go       = start & ~stop & (st == IDLE || st == DONE);
    act      = (st == PRE) || (st == ARMED) || (st == POST);
    wr       = smp_en & act
             & ~(st == PRE  && pre_q  == '0)
             & ~(st == POST && post_q == '0);
    edge_hit = 1'b0;
    unique case (edge_q)
      2'b00:   edge_hit = positive;
      2'b01:   edge_hit = negative;
      2'b10:   edge_hit = positive | negative;
      default: edge_hit = 1'b1;
    endcase
    hit      = edge_hit & smp_en & (st == ARMED);
    // timeout counter equals number of untriggered ARMED samples so far
    tmo_hit  = smp_en & (st == ARMED) & auto_q & (tmo_cnt == tmo_q);
    fire     = hit | tmo_hit;
    nxt      = st;
    unique case (st)
      IDLE, DONE: if (go) nxt = PRE;
      PRE:
        if (pre_q == '0 || (wr && cnt == pre_q - A1))
          nxt = ARMED;
      ARMED: if (fire) nxt = POST;
      POST:
        if (post_q == '0 || (wr && cnt == post_q - A1))
          nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (stop) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q     <= '0;
      auto_q     <= 1'b0;
      pre_q      <= '0;
      post_q     <= '0;
      tmo_q      <= '0;
      ptr        <= '0;
      cnt        <= '0;
      tmo_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      trig_addr  <= '0;
      triggered  <= 1'b0;
      auto_fired <= 1'b0;
    end else if (stop) begin
      wr_en      <= 1'b0;
      triggered  <= 1'b0;
      auto_fired <= 1'b0;
      cnt        <= '0;
      tmo_cnt    <= '0;
    end else begin
      wr_en     <= wr;
      triggered <= fire;
      if (go) begin
        edge_q     <= cfg_edge;
        auto_q     <= cfg_auto;
        pre_q      <= cfg_pre;
        post_q     <= cfg_post;
        tmo_q      <= cfg_tmo;
        ptr        <= '0;
        cnt        <= '0;
        trig_addr  <= '0;
        auto_fired <= 1'b0;
      end else begin
        if (wr) begin
          wr_addr <= ptr;
          ptr     <= ptr + A1;
        end
        if (nxt != st) cnt <= '0;
        else if (wr)   cnt <= cnt + A1;
        if (fire) begin
          trig_addr  <= ptr;
          auto_fired <= ~hit;
        end
        if (st != ARMED)
          tmo_cnt <= '0;
        else if (smp_en && !fire && !(&tmo_cnt))
          tmo_cnt <= tmo_cnt + T1;
      end
    end
  end

  assign busy  = act;
  assign done  = (st == DONE);
  assign state = st;

endmodule

// File: tb/tb_scope_trig_ctrl.sv
// tb_scope_trig_ctrl: randomized scoreboard bench for scope_trig_ctrl.
// Expected buffer writes come from a window-level model of one capture.
`timescale 1ns/1ps
module tb_scope_trig_ctrl;
  localparam int AW = 4;
  localparam int TW = 16;

  logic clk = 0, rst_n = 0, start = 0, stop = 0;
  logic smp_en = 0, positive = 0, negative = 0;
  logic [1:0] cfg_edge = 0;
  logic cfg_auto = 0;
  logic [AW-1:0] cfg_pre = 0, cfg_post = 0;
  logic [TW-1:0] cfg_tmo = 0;
  logic wr_en, triggered, auto_fired, busy, done;
  logic [AW-1:0] wr_addr, trig_addr;
  logic [2:0] state;

  typedef struct { int addr; bit trig; int k; } exp_t;
  exp_t sb[$];
  bit pos_a[256];
  bit neg_a[256];
  int smp_cyc[256];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  scope_trig_ctrl #(.ADDR_W(AW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .smp_en(smp_en), .positive(positive), .negative(negative),
    .cfg_edge(cfg_edge), .cfg_auto(cfg_auto), .cfg_pre(cfg_pre),
    .cfg_post(cfg_post), .cfg_tmo(cfg_tmo), .wr_en(wr_en),
    .wr_addr(wr_addr), .trig_addr(trig_addr), .triggered(triggered),
    .auto_fired(auto_fired), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit cond(input logic [1:0] ed, input bit p, input bit n);
    case (ed)
      2'b00:   return p;
      2'b01:   return n;
      2'b10:   return p | n;
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_write: got addr %0d expected no write", wr_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("trig_pulse", triggered, e.trig);
          chk("wr_latency", cyc - smp_cyc[e.k], 1);
        end
      end else if (triggered) begin
        checks++;
        errors++;
        $display("FAIL stray_trig: got triggered=1 expected 0 without write");
      end
    end
  end

  task automatic clear_flags();
    for (int i = 0; i < 256; i++) begin
      pos_a[i] = 0;
      neg_a[i] = 0;
    end
  endtask

  task automatic rand_flags();
    for (int i = 0; i < 256; i++) begin
      pos_a[i] = ($urandom_range(0, 7) == 0);
      neg_a[i] = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_left", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  // model: pre samples fill history, then the first ARMED sample whose
  // edge matches (or whose index hits the timeout in auto mode) triggers
  task automatic capture(input logic [1:0] ed, input bit aut,
                         input int pre, input int post, input int tmo,
                         input int n, input int gap);
    int tk, nw, g, est;
    bit af;
    exp_t x;
    tk = -1;
    af = 0;
    for (int j = 0; pre + j < n; j++) begin
      bit e, t;
      e = cond(ed, pos_a[pre+j], neg_a[pre+j]);
      t = aut && (j == tmo);
      if (e || t) begin
        tk = pre + j;
        af = !e;
        break;
      end
    end
    if (tk < 0) nw = n;
    else nw = (tk + 1 + post < n) ? tk + 1 + post : n;
    for (int k = 0; k < nw; k++) begin
      x.addr = k % 16;
      x.trig = (k == tk);
      x.k = k;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    cfg_edge = ed;
    cfg_auto = aut;
    cfg_pre = AW'(pre);
    cfg_post = AW'(post);
    cfg_tmo = TW'(tmo);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cfg_edge = 2'($urandom);
    cfg_auto = 1'($urandom);
    cfg_pre = AW'($urandom);
    cfg_post = AW'($urandom);
    cfg_tmo = TW'($urandom);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      g = (gap == 0) ? $urandom_range(1, 3) : gap;
      for (int i = 1; i < g; i++) begin
        smp_en = 0;
        positive = 1'($urandom);
        negative = 1'($urandom);
        @(posedge clk); #1;
      end
      smp_en = 1;
      positive = pos_a[k];
      negative = neg_a[k];
      smp_cyc[k] = cyc;
      @(posedge clk); #1;
    end
    smp_en = 0;
    positive = 0;
    negative = 0;
    drain();
    if (tk >= 0 && tk + 1 + post <= n) est = 4;
    else if (tk >= 0) est = 3;
    else est = 2;
    chk("state", state, est);
    chk("busy", busy, est != 4);
    chk("done", done, est == 4);
    if (tk >= 0) begin
      chk("trig_addr", trig_addr, tk % 16);
      chk("auto_fired", auto_fired, af);
    end
  endtask

  task automatic do_stop();
    stop = 1;
    start = 1;
    smp_en = 1;
    positive = 1;
    @(posedge clk); #1;
    stop = 0;
    start = 0;
    smp_en = 0;
    positive = 0;
    chk("stop_state", state, 0);
    chk("stop_wr_en", wr_en, 0);
    chk("stop_done", done, 0);
    chk("stop_busy", busy, 0);
    chk("stop_auto", auto_fired, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_addr", trig_addr, 0);
    rst_n = 1;

    // positive edge on 6th sample; an edge during PRE must be ignored
    clear_flags();
    pos_a[1] = 1;
    pos_a[5] = 1;
    neg_a[3] = 1;
    capture(2'b00, 0, 3, 2, 0, 12, 1);

    // negative-edge mode fed only positive flags: stays armed and wraps
    rand_flags();
    for (int i = 0; i < 256; i++) neg_a[i] = 0;
    capture(2'b01, 0, 3, 2, 0, 100, 1);
    do_stop();

    // auto trigger after timeout with no edges
    clear_flags();
    capture(2'b00, 1, 0, 1, 4, 10, 1);

    // immediate trigger, sparse strobes
    clear_flags();
    capture(2'b11, 0, 2, 0, 0, 6, 3);

    // abort with start during POST
    clear_flags();
    pos_a[4] = 1;
    capture(2'b00, 0, 2, 8, 0, 7, 1);
    do_stop();

    // real edge coincides with timeout
    clear_flags();
    pos_a[2] = 1;
    capture(2'b00, 1, 0, 1, 2, 6, 1);

    for (int r = 0; r < 12; r++) begin
      rand_flags();
      capture(2'($urandom), 1'($urandom), $urandom_range(0, 5),
              $urandom_range(0, 5), $urandom_range(0, 12), 30, 0);
      if (state != 3'd4) do_stop();
    end

    // asynchronous reset while armed
    clear_flags();
    capture(2'b00, 0, 1, 1, 0, 5, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_trig_addr", trig_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_auto", auto_fired, 0);
    chk("arst_triggered", triggered, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
